// File: rtl/core_pkg.sv
// Shared definitions for the boot loader: state encoding and image header layout.
package core_pkg;

    typedef enum logic [3:0] {
        IDLE,
        HDR_REQ,
        HDR_WAIT,
        DAT_REQ,
        DAT_WAIT,
        SUM_REQ,
        SUM_WAIT,
        DONE,
        ERR
    } loader_state_t;

    localparam int BOOT_BASE_DEF = 0;
    localparam int HDR_LEN       = 0;
    localparam int PAYLOAD_OFS   = 1;

endpackage

// File: rtl/os_loader.sv
// Boot-image loader: copies a length-prefixed, checksummed image from boot ROM into IMEM.
//  state    | meaning
//  IDLE     | waiting for load_os
//  HDR_REQ  | header read strobe on the bus
//  HDR_WAIT | waiting for payload length
//  DAT_REQ  | payload read strobe on the bus
//  DAT_WAIT | waiting for payload word, written to IMEM on arrival
//  SUM_REQ  | checksum read strobe on the bus
//  SUM_WAIT | waiting for checksum word
//  DONE     | image good, done held while load_os stays high
//  ERR      | bad image, sticky until reset
module os_loader
    import core_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ROM_AW    = 12,
    parameter int IMEM_AW   = 10,
    parameter int BOOT_BASE = BOOT_BASE_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               reset_all,
    input  logic               load_os,
    output logic               load_os_done,
    output logic               load_os_err,
    output logic               rom_req,
    output logic [ROM_AW-1:0]  rom_addr,
    input  logic               rom_rvalid,
    input  logic [DATA_W-1:0]  rom_rdata,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [DATA_W-1:0]  imem_wdata
);

    localparam int CW         = IMEM_AW + 1;
    localparam int IMEM_DEPTH = 2 ** IMEM_AW;
    localparam logic [ROM_AW-1:0] HDR_A = ROM_AW'(BOOT_BASE) + ROM_AW'(HDR_LEN);
    localparam logic [ROM_AW-1:0] PAY_A = ROM_AW'(BOOT_BASE) + ROM_AW'(PAYLOAD_OFS);

    loader_state_t     state;
    logic [CW-1:0]     len;
    logic [CW-1:0]     idx;
    logic [DATA_W-1:0] sum;
    logic [CW-1:0]     idx_nxt;

    assign idx_nxt = idx + CW'(1);

    always_ff @(posedge clk) begin
        rom_req <= 1'b0;
        imem_we <= 1'b0;
        if (rst || reset_all) begin
            state        <= IDLE;
            len          <= '0;
            idx          <= '0;
            sum          <= '0;
            rom_addr     <= '0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            load_os_done <= 1'b0;
            load_os_err  <= 1'b0;
        end else if (!load_os && state != DONE && state != ERR) begin
            // abort: any in-flight read is simply never consumed
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state    <= HDR_REQ;
                    rom_req  <= 1'b1;
                    rom_addr <= HDR_A;
                end
                HDR_REQ:  state <= HDR_WAIT;
                HDR_WAIT: if (rom_rvalid) begin
                    len <= rom_rdata[CW-1:0];
                    idx <= '0;
                    sum <= '0;
                    if (rom_rdata > DATA_W'(IMEM_DEPTH)) begin
                        state       <= ERR;
                        load_os_err <= 1'b1;
                    end else begin
                        state    <= (rom_rdata == '0) ? SUM_REQ : DAT_REQ;
                        rom_req  <= 1'b1;
                        rom_addr <= PAY_A;
                    end
                end
                DAT_REQ:  state <= DAT_WAIT;
                DAT_WAIT: if (rom_rvalid) begin
                    imem_we    <= 1'b1;
                    imem_addr  <= idx[IMEM_AW-1:0];
                    imem_wdata <= rom_rdata;
                    sum        <= sum + rom_rdata;
                    idx        <= idx_nxt;
                    // checksum sits right after the last payload word, so one address formula serves both
                    state      <= (idx_nxt == len) ? SUM_REQ : DAT_REQ;
                    rom_req    <= 1'b1;
                    rom_addr   <= PAY_A + ROM_AW'(idx_nxt);
                end
                SUM_REQ:  state <= SUM_WAIT;
                SUM_WAIT: if (rom_rvalid) begin
                    if (rom_rdata == sum) begin
                        state        <= DONE;
                        load_os_done <= 1'b1;
                    end else begin
                        state       <= ERR;
                        load_os_err <= 1'b1;
                    end
                end
                DONE: if (!load_os) begin
                    state        <= IDLE;
                    load_os_done <= 1'b0;
                end
                ERR:      state <= ERR;
                default:  state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_os_loader.sv
// Self-checking bench for os_loader: ROM responder, image model and per-cycle bus scoreboard.
module tb_os_loader;

    localparam int DATA_W    = 32;
    localparam int ROM_AW    = 12;
    localparam int IMEM_AW   = 10;
    localparam int DEPTH     = 1 << IMEM_AW;
    localparam int ROM_WORDS = 1 << ROM_AW;
    localparam int BASE      = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst = 1'b1, rst_inj = 1'b0, reset_all = 1'b0, load_os = 1'b0;
    logic               rom_rvalid = 1'b0;
    logic [DATA_W-1:0]  rom_rdata = '0;
    logic               load_os_done, load_os_err, rom_req, imem_we;
    logic [ROM_AW-1:0]  rom_addr;
    logic [IMEM_AW-1:0] imem_addr;
    logic [DATA_W-1:0]  imem_wdata;

    os_loader #(.DATA_W(DATA_W), .ROM_AW(ROM_AW), .IMEM_AW(IMEM_AW), .BOOT_BASE(BASE)) dut (
        .clk          (clk),
        .rst          (rst | rst_inj),
        .reset_all    (reset_all),
        .load_os      (load_os),
        .load_os_done (load_os_done),
        .load_os_err  (load_os_err),
        .rom_req      (rom_req),
        .rom_addr     (rom_addr),
        .rom_rvalid   (rom_rvalid),
        .rom_rdata    (rom_rdata),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata)
    );

    logic [31:0] rom_mem [ROM_WORDS];
    logic [31:0] imem_sh [DEPTH];
    int          exp_rd[$];
    int          exp_wa[$];
    logic [31:0] exp_wd[$];
    int          exp_reads;
    bit          exp_ok;

    int n_checks = 0, n_fail = 0, cyc = 0, n_writes = 0, last_wa = -1;
    int abort_after = -1, inj_idx = -1, lat = 1, cnt = 0, paddr = 0, c = 0;
    bit lat_rand = 1'b0, pend = 1'b0, flush = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // one clock: scoreboard DUT outputs, then act as the ROM
    task automatic tick();
        @(negedge clk);
        cyc++;
        rst_inj    = 1'b0;
        rom_rvalid = 1'b0;
        check("done_err_exclusive", {1'b0, load_os_done & load_os_err}, 0);
        if (rom_req) begin
            if (exp_rd.size() == 0) check("rom_req_unexpected", rom_req, 0);
            else check("rom_addr", rom_addr, exp_rd.pop_front());
        end
        if (imem_we) begin
            if (exp_wa.size() == 0) check("imem_we_unexpected", imem_we, 0);
            else begin
                check("imem_addr", imem_addr, exp_wa.pop_front());
                check("imem_wdata", imem_wdata, exp_wd.pop_front());
            end
            imem_sh[imem_addr] = imem_wdata;
            last_wa = int'(imem_addr);
            n_writes++;
            if (n_writes == abort_after) begin
                load_os = 1'b0;
                flush   = 1'b1;
            end
        end
        if (pend) begin
            if (cnt <= 1) begin
                rom_rvalid = 1'b1;
                rom_rdata  = rom_mem[paddr];
                pend       = 1'b0;
                if (inj_idx >= 0 && paddr == (BASE + 1 + inj_idx) % ROM_WORDS) begin
                    rst_inj = 1'b1;
                    load_os = 1'b0;
                    inj_idx = -1;
                    flush   = 1'b1;
                end
            end else cnt--;
        end
        if (rom_req) begin
            check("one_read_outstanding", pend, 0);
            pend  = 1'b1;
            cnt   = lat_rand ? int'($urandom_range(5, 1)) : lat;
            paddr = int'(rom_addr);
        end
        if (flush) begin
            exp_rd.delete();
            exp_wa.delete();
            exp_wd.delete();
            flush = 1'b0;
        end
    endtask

    task automatic build_image(input int n, input int delta, input bit rnd);
        logic [31:0] s, w;
        s = 0;
        rom_mem[BASE % ROM_WORDS] = n;
        for (int i = 0; i < n; i++) begin
            w = rnd ? $urandom : 32'(i + 1);
            rom_mem[(BASE + 1 + i) % ROM_WORDS] = w;
            s += w;
        end
        rom_mem[(BASE + 1 + n) % ROM_WORDS] = s + 32'(delta);
    endtask

    // what the loader must do with whatever image currently sits in ROM
    task automatic model_expect();
        logic [31:0] len, s;
        exp_rd.delete();
        exp_wa.delete();
        exp_wd.delete();
        len = rom_mem[BASE % ROM_WORDS];
        exp_rd.push_back(BASE % ROM_WORDS);
        if (len > DEPTH) begin
            exp_reads = 1;
            exp_ok    = 1'b0;
        end else begin
            s = 0;
            for (int i = 0; i < int'(len); i++) begin
                exp_rd.push_back((BASE + 1 + i) % ROM_WORDS);
                exp_wa.push_back(i);
                exp_wd.push_back(rom_mem[(BASE + 1 + i) % ROM_WORDS]);
                s += rom_mem[(BASE + 1 + i) % ROM_WORDS];
            end
            exp_rd.push_back((BASE + 1 + int'(len)) % ROM_WORDS);
            exp_reads = int'(len) + 2;
            exp_ok    = (rom_mem[(BASE + 1 + int'(len)) % ROM_WORDS] == s);
        end
    endtask

    task automatic run_image(output int cycles);
        int st;
        n_writes = 0;
        model_expect();
        load_os = 1'b1;
        st = cyc;
        for (int k = 0; k < 5000; k++) begin
            if (exp_ok ? load_os_done : load_os_err) break;
            tick();
        end
        cycles = cyc - st;
        if (exp_ok) check("done_reached", load_os_done, 1);
        else        check("err_reached", load_os_err, 1);
        check("reads_all_issued", exp_rd.size(), 0);
        check("writes_all_seen", exp_wa.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_done"}, load_os_done, 0);
        check({tag, "_err"}, load_os_err, 0);
        check({tag, "_rom_req"}, rom_req, 0);
        check({tag, "_imem_we"}, imem_we, 0);
        check({tag, "_rom_addr"}, rom_addr, 0);
        check({tag, "_imem_addr"}, imem_addr, 0);
        check({tag, "_imem_wdata"}, imem_wdata, 0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic pulse_reset_all();
        reset_all = 1'b1;
        tick();
        check("reset_all_clears_err", load_os_err, 0);
        reset_all = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < ROM_WORDS; i++) rom_mem[i] = '0;
        for (int i = 0; i < DEPTH; i++) imem_sh[i] = '0;

        idle(3);
        rst = 1'b0;
        tick();
        check_all_zero("reset");

        // image {1,2,3,4}, checksum 10, latency 1
        lat = 1;
        build_image(4, 0, 1'b0);
        run_image(c);
        check("t1_cycles_l1", c, 13);
        check("t1_cycles_model", c, exp_reads * (1 + lat) + 1);
        for (int i = 0; i < 4; i++) check("t1_imem", imem_sh[i], i + 1);
        check("t1_err", load_os_err, 0);
        check("t1_writes", n_writes, 4);
        load_os = 1'b0;
        tick();
        check("t1_done_drop", load_os_done, 0);
        idle(4);

        // same image at latency 2
        lat = 2;
        run_image(c);
        check("t1b_cycles_l2", c, 19);
        load_os = 1'b0;
        tick();
        check("t1b_done_drop", load_os_done, 0);
        idle(4);

        // bad checksum: 11
        lat = 1;
        build_image(4, 1, 1'b0);
        run_image(c);
        check("t2_cycles", c, 13);
        check("t2_writes", n_writes, 4);
        load_os = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("t2_err_held", load_os_err, 1);
            check("t2_no_done", load_os_done, 0);
        end
        pulse_reset_all();
        idle(2);

        // empty image
        build_image(0, 0, 1'b0);
        run_image(c);
        check("t3_empty_cycles", c, 5);
        check("t3_empty_writes", n_writes, 0);
        load_os = 1'b0;
        idle(4);

        // oversize header
        build_image(DEPTH + 1, 0, 1'b0);
        run_image(c);
        check("t3_oversize_cycles", c, 3);
        check("t3_oversize_writes", n_writes, 0);
        check("t3_oversize_no_done", load_os_done, 0);
        load_os = 1'b0;
        pulse_reset_all();
        idle(2);

        // abort after 3rd write, random latency
        lat_rand = 1'b1;
        abort_after = 3;
        build_image(8, 0, 1'b1);
        n_writes = 0;
        model_expect();
        load_os = 1'b1;
        for (int k = 0; k < 500 && load_os; k++) tick();
        check("t4_abort_reached", load_os, 0);
        idle(20);
        check("t4_writes", n_writes, 3);
        check("t4_done", load_os_done, 0);
        check("t4_err", load_os_err, 0);
        abort_after = -1;
        lat_rand = 1'b0;

        // rst in DAT_WAIT coincident with rvalid of word 1
        lat = 1;
        build_image(4, 0, 1'b1);
        inj_idx = 1;
        n_writes = 0;
        model_expect();
        load_os = 1'b1;
        for (int k = 0; k < 200 && !rst_inj; k++) tick();
        check("t5_reset_injected", rst_inj, 1);
        tick();
        check_all_zero("t5");
        check("t5_writes", n_writes, 1);
        idle(10);

        // full IMEM
        build_image(DEPTH, 0, 1'b1);
        run_image(c);
        check("t6_cycles", c, 2053);
        check("t6_writes", n_writes, DEPTH);
        check("t6_last_addr", last_wa, 1023);
        load_os = 1'b0;
        tick();
        check("t6_done_drop", load_os_done, 0);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
